// File: rtl/control_movimiento.sv
// Timed motion-command sequencer feeding the movimiento direction decoder.
// Adds a stopped dead-time before reversals and stops on abort or a front obstacle.
module control_movimiento #(
    parameter int TICK_DIV   = 50000,
    parameter int DUR_W      = 16,
    parameter int DEAD_TICKS = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_dir,
    input  logic [DUR_W-1:0] cmd_dur,
    input  logic             obstacle,
    input  logic             abort,
    output logic [2:0]       estado,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status
);

    // state | meaning
    // IDLE  | stopped, ready for a command
    // DEAD  | stopped dead-time before a direction change
    // RUN   | driving the latched direction for the latched duration
    typedef enum logic [1:0] {IDLE, DEAD, RUN} state_t;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEAD_TICKS + 1);

    state_t           state, state_n;
    logic [PW-1:0]    presc, presc_n;
    logic [DW-1:0]    dead_cnt, dead_n;
    logic [DUR_W-1:0] remaining, rem_n, dur_q, dur_n;
    logic [2:0]       dir_q, dir_n, last_dir, last_dir_n, estado_n;
    logic             busy_n, done_n;
    logic [1:0]       status_n;
    logic             tick;

    assign tick      = (presc == PW'(TICK_DIV - 1));
    assign cmd_ready = (state == IDLE);

    always_comb begin
        state_n    = state;
        presc_n    = tick ? '0 : presc + PW'(1);
        dead_n     = dead_cnt;
        rem_n      = remaining;
        dur_n      = dur_q;
        dir_n      = dir_q;
        last_dir_n = last_dir;
        estado_n   = estado;
        busy_n     = busy;
        done_n     = 1'b0;
        status_n   = status;
        case (state)
            IDLE: begin
                estado_n = 3'b000;
                busy_n   = 1'b0;
                if (cmd_valid) begin
                    if (cmd_dir >= 3'd5) begin
                        done_n   = 1'b1;
                        status_n = 2'b11;
                    end else if (cmd_dir == 3'b000 || cmd_dur == '0) begin
                        done_n   = 1'b1;
                        status_n = 2'b00;
                    end else if (cmd_dir == 3'b001 && obstacle) begin
                        done_n   = 1'b1;
                        status_n = 2'b01;
                    end else begin
                        dir_n   = cmd_dir;
                        dur_n   = cmd_dur;
                        presc_n = '0;
                        busy_n  = 1'b1;
                        if (last_dir != 3'b000 && last_dir != cmd_dir) begin
                            state_n = DEAD;
                            dead_n  = DW'(DEAD_TICKS);
                        end else begin
                            state_n    = RUN;
                            estado_n   = cmd_dir;
                            last_dir_n = cmd_dir;
                            rem_n      = cmd_dur;
                        end
                    end
                end
            end
            DEAD, RUN: begin
                // abort outranks the obstacle stop, which outranks normal expiry
                if (abort || (obstacle && dir_q == 3'b001)) begin
                    state_n  = IDLE;
                    estado_n = 3'b000;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                    status_n = abort ? 2'b10 : 2'b01;
                end else if (tick) begin
                    if (state == DEAD) begin
                        if (dead_cnt == DW'(1)) begin
                            state_n    = RUN;
                            estado_n   = dir_q;
                            last_dir_n = dir_q;
                            rem_n      = dur_q;
                            presc_n    = '0;
                        end else begin
                            dead_n = dead_cnt - DW'(1);
                        end
                    end else begin
                        if (remaining == DUR_W'(1)) begin
                            state_n  = IDLE;
                            estado_n = 3'b000;
                            busy_n   = 1'b0;
                            done_n   = 1'b1;
                            status_n = 2'b00;
                        end else begin
                            rem_n = remaining - DUR_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_n  = IDLE;
                estado_n = 3'b000;
                busy_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            presc     <= '0;
            dead_cnt  <= '0;
            remaining <= '0;
            dur_q     <= '0;
            dir_q     <= 3'b000;
            last_dir  <= 3'b000;
            estado    <= 3'b000;
            busy      <= 1'b0;
            done      <= 1'b0;
            status    <= 2'b00;
        end else begin
            state     <= state_n;
            presc     <= presc_n;
            dead_cnt  <= dead_n;
            remaining <= rem_n;
            dur_q     <= dur_n;
            dir_q     <= dir_n;
            last_dir  <= last_dir_n;
            estado    <= estado_n;
            busy      <= busy_n;
            done      <= done_n;
            status    <= status_n;
        end
    end

endmodule

// File: tb/tb_control_movimiento.sv
// Directed bench for control_movimiento with TICK_DIV=4, DEAD_TICKS=2.
module tb_control_movimiento;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_dir = 3'b000;
    logic [15:0] cmd_dur = 16'd0;
    logic        obstacle = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  estado;
    logic        busy;
    logic        done;
    logic [1:0]  status;

    int n_chk  = 0;
    int n_pass = 0;
    int n;

    control_movimiento #(.TICK_DIV(4), .DUR_W(16), .DEAD_TICKS(2)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_dur(cmd_dur), .obstacle(obstacle), .abort(abort),
        .estado(estado), .busy(busy), .done(done), .status(status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // presents a command for one edge; returns one cycle after the acceptance edge
    task automatic send(input logic [2:0] d, input logic [15:0] t);
        chk("ready_before_send", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_dur   = t;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic count_while(input logic [2:0] est, input logic bsy, output int cnt);
        cnt = 0;
        while (estado == est && busy == bsy && cnt < 200) begin
            cnt++;
            step();
        end
    endtask

    task automatic chk_done(input string tag, input int st);
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_status"}, int'(status), st);
        chk({tag, "_estado"}, int'(estado), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #1;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("rst_estado", int'(estado), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_status", int'(status), 0);

        // timed forward
        send(3'b001, 16'd3);
        chk("fwd_busy", int'(busy), 1);
        count_while(3'b001, 1'b1, n);
        chk("fwd_len", n, 12);
        chk_done("fwd", 0);

        // reversal issued in the done cycle gets a dead-time
        send(3'b010, 16'd1);
        count_while(3'b000, 1'b1, n);
        chk("rev_dead_len", n, 8);
        count_while(3'b010, 1'b1, n);
        chk("rev_run_len", n, 4);
        chk_done("rev", 0);
        step();
        chk("done_one_cycle", int'(done), 0);

        // same direction again: no dead-time
        send(3'b010, 16'd1);
        chk("same_dir_estado", int'(estado), 2);
        count_while(3'b010, 1'b1, n);
        chk("same_dir_len", n, 4);
        chk_done("same_dir", 0);

        // obstacle during forward move (last_dir=010, so dead-time first)
        send(3'b001, 16'd10);
        count_while(3'b000, 1'b1, n);
        chk("obs_dead_len", n, 8);
        repeat (4) step();
        chk("obs_moving", int'(estado), 1);
        obstacle = 1'b1;
        step();
        chk_done("obs_run", 1);
        step();

        // obstacle at forward acceptance
        send(3'b001, 16'd5);
        chk_done("obs_accept", 1);

        // obstacle ignored while reversing
        send(3'b010, 16'd2);
        count_while(3'b000, 1'b1, n);
        chk("obs_rev_dead", n, 8);
        count_while(3'b010, 1'b1, n);
        chk("obs_rev_run", n, 8);
        chk_done("obs_rev", 0);
        obstacle = 1'b0;

        // abort on cycle 3 of DEAD
        send(3'b001, 16'd2);
        chk("abort_dead_busy", int'(busy), 1);
        repeat (2) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_done("abort_dead", 2);

        // invalid direction and zero-duration no-op
        send(3'b110, 16'd5);
        chk_done("invalid", 3);
        send(3'b011, 16'd0);
        chk_done("zero_dur", 0);

        // command presented while abort is held: accepted, then aborted
        abort = 1'b1;
        send(3'b010, 16'd3);
        chk("abort_cmd_run", int'(estado), 2);
        step();
        abort = 1'b0;
        chk_done("abort_cmd", 2);

        // reset mid-RUN clears last_dir; no done pulse
        send(3'b100, 16'd5);
        count_while(3'b000, 1'b1, n);
        chk("rst_mid_dead", n, 8);
        repeat (2) step();
        chk("rst_mid_run", int'(estado), 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_estado", int'(estado), 0);
        chk("rst_mid_done", int'(done), 0);
        chk("rst_mid_busy", int'(busy), 0);
        step();
        chk("rst_mid_done2", int'(done), 0);
        send(3'b011, 16'd1);
        chk("post_rst_no_dead", int'(estado), 3);
        count_while(3'b011, 1'b1, n);
        chk("post_rst_len", n, 4);
        chk_done("post_rst", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
